// File: rtl/lap_stopwatch.sv
// BCD lap stopwatch: hh:mm:ss plus sub-second digits, up/down count,
// preset load, done flag, and a first-word-fall-through lap FIFO.
module lap_stopwatch #(
  parameter int TICK_DIV      = 100000,
  parameter int SUBSEC_DIGITS = 1,
  parameter int HOUR_MAX      = 23,
  parameter int LAP_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_stop,
  input  logic                          clear,
  input  logic                          load,
  input  logic [23:0]                   preset,
  input  logic                          mode,
  input  logic                          lap,
  input  logic                          lap_rd,
  output logic [3:0]                    hour2_q,
  output logic [3:0]                    hour1_q,
  output logic [3:0]                    min2_q,
  output logic [3:0]                    min1_q,
  output logic [3:0]                    sec2_q,
  output logic [3:0]                    sec1_q,
  output logic [4*SUBSEC_DIGITS-1:0]    sub_q,
  output logic [23+4*SUBSEC_DIGITS:0]   lap_data,
  output logic                          lap_empty,
  output logic                          lap_full,
  output logic                          lap_ovf,
  output logic                          running,
  output logic                          done
);

  localparam int SD = SUBSEC_DIGITS;
  localparam int ND = SD + 4;
  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int LW = 24 + 4 * SD;
  localparam logic [3:0] HMAX2 = 4'(HOUR_MAX / 10);
  localparam logic [3:0] HMAX1 = 4'(HOUR_MAX % 10);

  // dig_q[0] is the least significant sub-second digit; s1,s2,m1,m2 follow
  logic [3:0]    dig_q [ND];
  logic [3:0]    h2_q, h1_q;
  logic [PW-1:0] presc_q;
  logic          mode_q;

  logic [3:0] up_d [ND];
  logic [3:0] dn_d [ND];
  logic [3:0] ld_d [ND];
  logic [3:0] up_h2, up_h1, dn_h2, dn_h1, ld_h2, ld_h1;
  logic [3:0] h2c, h1c;
  logic       up_c, dn_b;
  logic       tick, zero_now, zero_dn;
  int         hv;

  logic [LW-1:0] mem [LAP_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [LW-1:0] cur_time;
  logic          push_ok, pop_ok;

  function automatic logic [3:0] dmax(int i);
    if (i < SD) return 4'd9;
    return ((i - SD) % 2 == 0) ? 4'd9 : 4'd5;
  endfunction

  assign tick = running && (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    up_c  = 1'b1;
    up_h2 = h2_q;
    up_h1 = h1_q;
    for (int i = 0; i < ND; i++) begin
      up_d[i] = dig_q[i];
      if (up_c) begin
        if (dig_q[i] == dmax(i)) begin
          up_d[i] = 4'd0;
        end else begin
          up_d[i] = dig_q[i] + 4'd1;
          up_c    = 1'b0;
        end
      end
    end
    if (up_c) begin
      if (h2_q == HMAX2 && h1_q == HMAX1) begin
        up_h2 = 4'd0;
        up_h1 = 4'd0;
      end else if (h1_q == 4'd9) begin
        up_h2 = h2_q + 4'd1;
        up_h1 = 4'd0;
      end else begin
        up_h1 = h1_q + 4'd1;
      end
    end
  end

  always_comb begin
    dn_b  = 1'b1;
    dn_h2 = h2_q;
    dn_h1 = h1_q;
    for (int i = 0; i < ND; i++) begin
      dn_d[i] = dig_q[i];
      if (dn_b) begin
        if (dig_q[i] == 4'd0) begin
          dn_d[i] = dmax(i);
        end else begin
          dn_d[i] = dig_q[i] - 4'd1;
          dn_b    = 1'b0;
        end
      end
    end
    if (dn_b) begin
      if (h2_q == 4'd0 && h1_q == 4'd0) begin
        dn_h2 = HMAX2;
        dn_h1 = HMAX1;
      end else if (h1_q == 4'd0) begin
        dn_h2 = h2_q - 4'd1;
        dn_h1 = 4'd9;
      end else begin
        dn_h1 = h1_q - 4'd1;
      end
    end
  end

  always_comb begin
    zero_now = (h2_q == 4'd0) && (h1_q == 4'd0);
    zero_dn  = (dn_h2 == 4'd0) && (dn_h1 == 4'd0);
    for (int i = 0; i < ND; i++) begin
      if (dig_q[i] != 4'd0) zero_now = 1'b0;
      if (dn_d[i] != 4'd0) zero_dn = 1'b0;
    end
  end

  // Preset clamp: each digit to its legal max, then hours to HOUR_MAX
  always_comb begin
    for (int i = 0; i < ND; i++) begin
      ld_d[i] = 4'd0;
    end
    for (int k = 0; k < 4; k++) begin
      ld_d[SD+k] = (preset[4*k +: 4] > dmax(SD + k)) ?
                   dmax(SD + k) : preset[4*k +: 4];
    end
    h2c = (preset[23:20] > 4'd9) ? 4'd9 : preset[23:20];
    h1c = (preset[19:16] > 4'd9) ? 4'd9 : preset[19:16];
    hv  = int'(h2c) * 10 + int'(h1c);
    if (hv > HOUR_MAX) begin
      ld_h2 = HMAX2;
      ld_h1 = HMAX1;
    end else begin
      ld_h2 = h2c;
      ld_h1 = h1c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ND; i++) dig_q[i] <= 4'd0;
      h2_q    <= 4'd0;
      h1_q    <= 4'd0;
      presc_q <= '0;
      mode_q  <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (!running) mode_q <= mode;
      if (clear) begin
        for (int i = 0; i < ND; i++) dig_q[i] <= 4'd0;
        h2_q    <= 4'd0;
        h1_q    <= 4'd0;
        presc_q <= '0;
        running <= 1'b0;
        done    <= 1'b0;
      end else if (load && !running) begin
        for (int i = 0; i < ND; i++) dig_q[i] <= ld_d[i];
        h2_q    <= ld_h2;
        h1_q    <= ld_h1;
        presc_q <= '0;
        done    <= 1'b0;
      end else if (start_stop) begin
        if (running) begin
          running <= 1'b0;
        end else if (!(mode && zero_now)) begin
          running <= 1'b1;
          done    <= 1'b0;
        end
      end else if (tick) begin
        presc_q <= '0;
        if (!mode_q) begin
          for (int i = 0; i < ND; i++) dig_q[i] <= up_d[i];
          h2_q <= up_h2;
          h1_q <= up_h1;
        end else if (zero_now) begin
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          for (int i = 0; i < ND; i++) dig_q[i] <= dn_d[i];
          h2_q <= dn_h2;
          h1_q <= dn_h1;
          if (zero_dn) begin
            running <= 1'b0;
            done    <= 1'b1;
          end
        end
      end else if (running) begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  assign hour2_q = h2_q;
  assign hour1_q = h1_q;
  assign min2_q  = dig_q[SD+3];
  assign min1_q  = dig_q[SD+2];
  assign sec2_q  = dig_q[SD+1];
  assign sec1_q  = dig_q[SD];

  for (genvar g = 0; g < SD; g++) begin : g_sub
    assign sub_q[4*g +: 4] = dig_q[g];
  end

  assign cur_time  = {h2_q, h1_q, min2_q, min1_q, sec2_q, sec1_q, sub_q};
  assign lap_empty = (wr_ptr == rd_ptr);
  assign lap_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop paired with a push frees the slot the push needs
  assign push_ok   = lap && (!lap_full || lap_rd);
  assign pop_ok    = lap_rd && !lap_empty;
  assign lap_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lap_ovf <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lap_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (lap && lap_full && !lap_rd) lap_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear && push_ok) mem[wr_ptr[AW-1:0]] <= cur_time;
  end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Randomised bench for lap_stopwatch against a model that keeps time
// as a plain count of hundredths and the lap FIFO as a queue.
module tb_lap_stopwatch;

  localparam int MOD = 24 * 360000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [23:0] preset = '0;
  logic        mode = 1'b0;
  logic        lap = 1'b0;
  logic        lap_rd = 1'b0;
  logic [3:0]  hour2_q, hour1_q, min2_q, min1_q, sec2_q, sec1_q;
  logic [7:0]  sub_q;
  logic [31:0] lap_data;
  logic        lap_empty, lap_full, lap_ovf, running, done;

  int total = 0;
  int bad = 0;

  int m_t, m_p;
  bit m_run, m_done, m_ovf, m_mode;
  int q[$];

  lap_stopwatch #(
    .TICK_DIV(4), .SUBSEC_DIGITS(2), .HOUR_MAX(23), .LAP_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
    .load(load), .preset(preset), .mode(mode), .lap(lap),
    .lap_rd(lap_rd), .hour2_q(hour2_q), .hour1_q(hour1_q),
    .min2_q(min2_q), .min1_q(min1_q), .sec2_q(sec2_q),
    .sec1_q(sec1_q), .sub_q(sub_q), .lap_data(lap_data),
    .lap_empty(lap_empty), .lap_full(lap_full), .lap_ovf(lap_ovf),
    .running(running), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] to_bcd(int t);
    int cs, s, m, h;
    cs = t % 100;
    s  = (t / 100) % 60;
    m  = (t / 6000) % 60;
    h  = t / 360000;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic int dmin(int v, int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic int clamp_preset(logic [23:0] p);
    int h, m, s;
    h = dmin(dmin(int'(p[23:20]), 9) * 10 + dmin(int'(p[19:16]), 9), 23);
    m = dmin(int'(p[15:12]), 5) * 10 + dmin(int'(p[11:8]), 9);
    s = dmin(int'(p[7:4]), 5) * 10 + dmin(int'(p[3:0]), 9);
    return ((h * 60 + m) * 60 + s) * 100;
  endfunction

  function automatic logic [31:0] get_time();
    return {hour2_q, hour1_q, min2_q, min1_q, sec2_q, sec1_q, sub_q};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_p = 0; m_run = 0; m_done = 0; m_ovf = 0; m_mode = 0;
    q.delete();
  endtask

  task automatic check_all();
    chk("time", get_time(), to_bcd(m_t));
    chk("running", 32'(running), 32'(m_run));
    chk("done", 32'(done), 32'(m_done));
    chk("empty", 32'(lap_empty), 32'(q.size() == 0));
    chk("full", 32'(lap_full), 32'(q.size() == 4));
    chk("ovf", 32'(lap_ovf), 32'(m_ovf));
    if (q.size() > 0) chk("lap_data", lap_data, to_bcd(q[0]));
  endtask

  // Advance the model by one clock edge using the inputs now applied
  task automatic model_edge();
    bit prev_run, popok, pushok;
    int cur;
    prev_run = m_run;
    cur = m_t;
    if (clear) begin
      q.delete();
      m_ovf = 0;
    end else begin
      popok  = lap_rd && (q.size() > 0);
      pushok = lap && ((q.size() < 4) || lap_rd);
      if (lap && q.size() == 4 && !lap_rd) m_ovf = 1;
      if (popok) void'(q.pop_front());
      if (pushok) q.push_back(cur);
    end
    if (clear) begin
      m_t = 0; m_p = 0; m_run = 0; m_done = 0;
    end else if (load && !m_run) begin
      m_t = clamp_preset(preset); m_p = 0; m_done = 0;
    end else if (start_stop) begin
      if (m_run) m_run = 0;
      else if (!(mode && m_t == 0)) begin
        m_run = 1; m_done = 0;
      end
    end else if (m_run) begin
      if (m_p == 3) begin
        m_p = 0;
        if (!m_mode) m_t = (m_t + 1) % MOD;
        else begin
          m_t = m_t - 1;
          if (m_t == 0) begin
            m_run = 0; m_done = 1;
          end
        end
      end else m_p++;
    end
    if (!prev_run) m_mode = mode;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    start_stop = 0; clear = 0; load = 0; lap = 0; lap_rd = 0;
  endtask

  task automatic async_reset(bit busy);
    #3;
    if (busy) begin
      clear = 1; load = 1; start_stop = 1; preset = 24'h123456;
    end
    rst = 1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 0; clear = 0; load = 0; start_stop = 0; lap = 0; lap_rd = 0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 0;

    mode = 0; start_stop = 1; step();
    repeat (400) step();
    chk("one_sec", get_time(), 32'h0000_0100);
    start_stop = 1; step();
    repeat (40) step();
    chk("held", get_time(), 32'h0000_0100);
    start_stop = 1; step();
    repeat (10) step();

    start_stop = 1; step();
    clear = 1; step();
    load = 1; preset = 24'h235959; step();
    start_stop = 1; step();
    repeat (400) step();
    chk("wrap", get_time(), 32'h0);
    chk("wrap_run", 32'(running), 32'd1);

    start_stop = 1; step();
    mode = 1; load = 1; preset = 24'h000001; step();
    start_stop = 1; step();
    repeat (400) step();
    chk("down_zero", get_time(), 32'h0);
    chk("down_stop", 32'(running), 32'd0);
    chk("down_done", 32'(done), 32'd1);
    start_stop = 1; step();
    chk("start_ign", 32'(running), 32'd0);

    load = 1; preset = 24'h010000; step();
    start_stop = 1; step();
    repeat (4) step();
    chk("borrow", get_time(), 32'h0059_5999);

    start_stop = 1; step();
    mode = 0; clear = 1; step();
    start_stop = 1; step();
    for (int k = 0; k < 5; k++) begin
      repeat (3) step();
      lap = 1; step();
    end
    chk("lap_full", 32'(lap_full), 32'd1);
    chk("lap_ovf", 32'(lap_ovf), 32'd1);
    for (int k = 0; k < 4; k++) begin
      lap_rd = 1; step();
    end
    chk("lap_drain", 32'(lap_empty), 32'd1);

    lap = 1; step();
    clear = 1; load = 1; start_stop = 1; lap = 1; preset = 24'h123456;
    step();
    chk("clr_win", get_time(), 32'h0);
    chk("clr_fifo", 32'(lap_empty), 32'd1);

    start_stop = 1; step();
    repeat (13) step();
    lap = 1; step();
    async_reset(0);
    start_stop = 1; step();
    repeat (9) step();
    async_reset(1);

    for (int n = 0; n < 5000; n++) begin
      start_stop = ($urandom % 40) == 0;
      clear      = ($urandom % 300) == 0;
      load       = ($urandom % 25) == 0;
      lap        = ($urandom % 6) == 0;
      lap_rd     = ($urandom % 7) == 0;
      if (($urandom % 60) == 0) mode = ~mode;
      preset = ($urandom % 2) ? 24'($urandom) : 24'($urandom % 3);
      if (($urandom % 1500) == 0) async_reset(1);
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
